// File: rtl/hdmi_pkg.sv
// ============================================================================
// hdmi_pkg : default 640x480@60 raster constants, counter widths, bar colours
// Rev 1.0
// ============================================================================
`default_nettype none

package hdmi_pkg;

  localparam int H_CNT_W = 12;
  localparam int V_CNT_W = 11;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int NUM_BARS = 8;

  typedef logic [23:0] rgb_t;
  typedef logic [2:0]  bar_idx_t;

  // Classic SMPTE-style order, {R,G,B}
  localparam rgb_t BAR_COLORS [NUM_BARS] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

`default_nettype wire

// File: rtl/colorbar_gen.sv
// ============================================================================
// colorbar_gen : 8-bar test pattern, bar index tracked by a pixel counter
// Rev 1.0
// ============================================================================
`default_nettype none

module colorbar_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic               pixclk,
  input  logic               reset,
  input  logic [H_CNT_W-1:0] h,
  input  logic [V_CNT_W-1:0] v,
  input  logic               active,
  output rgb_t               rgb
);

  localparam int BAR_W = H_ACTIVE / NUM_BARS;

  localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] SEG_LAST   = H_CNT_W'(BAR_W - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_LINE = V_CNT_W'(V_ACTIVE);

  logic [H_CNT_W-1:0] seg_cnt;
  bar_idx_t           bar_idx;
  logic               line_end;
  logic               vblank;

  // State describes the pixel currently held in h, so it is cleared on the
  // cycle before h wraps back to 0.
  assign line_end = (h == H_LAST);
  assign vblank   = (v >= V_ACT_LINE);

  always_ff @(posedge pixclk) begin
    if (reset || line_end || vblank) begin
      seg_cnt <= '0;
      bar_idx <= '0;
    end else if (seg_cnt == SEG_LAST) begin
      seg_cnt <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      seg_cnt <= seg_cnt + 1'b1;
    end
  end

  assign rgb = active ? BAR_COLORS[bar_idx] : '0;

endmodule

`default_nettype wire

// File: rtl/hdmi_video_timing.sv
// ============================================================================
// hdmi_video_timing : free-running raster generator with colour-bar pattern
// Rev 1.0
// ============================================================================
`default_nettype none

module hdmi_video_timing
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic               pixclk,
  input  logic               reset,
  output logic               DE,
  output logic               hsync,
  output logic               vsync,
  output logic [1:0]         ctrl_b,
  output logic [H_CNT_W-1:0] x,
  output logic [V_CNT_W-1:0] y,
  output logic               frame_start,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT_C  = H_CNT_W'(H_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_ACT_C  = V_CNT_W'(V_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_START = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               h_wrap;
  logic               active;
  logic               hs_on;
  logic               vs_on;
  logic               hs_lvl;
  logic               vs_lvl;
  rgb_t               bar_rgb;

  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge pixclk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) begin
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
    end
  end

  // v_cnt only moves on h wrap, so vsync edges land on h=0 by construction.
  assign active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_on  = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_on  = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign hs_lvl = hs_on ? HSYNC_POL : ~HSYNC_POL;
  assign vs_lvl = vs_on ? VSYNC_POL : ~VSYNC_POL;

  colorbar_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE)
  ) u_colorbar (
    .pixclk (pixclk),
    .reset  (reset),
    .h      (h_cnt),
    .v      (v_cnt),
    .active (active),
    .rgb    (bar_rgb)
  );

  always_ff @(posedge pixclk) begin
    if (reset) begin
      DE          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      ctrl_b      <= {~VSYNC_POL, ~HSYNC_POL};
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      DE          <= active;
      hsync       <= hs_lvl;
      vsync       <= vs_lvl;
      ctrl_b      <= {vs_lvl, hs_lvl};
      x           <= active ? h_cnt : '0;
      y           <= active ? v_cnt : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      red         <= bar_rgb[23:16];
      green       <= bar_rgb[15:8];
      blue        <= bar_rgb[7:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hdmi_video_timing.sv
// ============================================================================
// tb_hdmi_video_timing : scoreboard bench, default DUT plus a small-raster DUT
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hdmi_video_timing;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [1:0]  cb;
    logic [11:0] x;
    logic [10:0] y;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  localparam int S_HA = 32, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  logic pixclk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  logic        DE0, hsync0, vsync0, fs0, DE1, hsync1, vsync1, fs1;
  logic [1:0]  ctrl_b0, ctrl_b1;
  logic [11:0] x0, x1;
  logic [10:0] y0, y1;
  logic [7:0]  red0, green0, blue0, red1, green1, blue1;

  exp_t act0, act1, e0, e1;
  exp_t q0[$];
  exp_t q1[$];
  int   mh0 = 0, mv0 = 0, mh1 = 0, mv1 = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 pixclk = ~pixclk;

  hdmi_video_timing dut0 (
    .pixclk(pixclk), .reset(rst0), .DE(DE0), .hsync(hsync0), .vsync(vsync0),
    .ctrl_b(ctrl_b0), .x(x0), .y(y0), .frame_start(fs0),
    .red(red0), .green(green0), .blue(blue0)
  );

  hdmi_video_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut1 (
    .pixclk(pixclk), .reset(rst1), .DE(DE1), .hsync(hsync1), .vsync(vsync1),
    .ctrl_b(ctrl_b1), .x(x1), .y(y1), .frame_start(fs1),
    .red(red1), .green(green1), .blue(blue1)
  );

  assign act0 = {DE0, hsync0, vsync0, ctrl_b0, x0, y0, fs0, red0, green0, blue0};
  assign act1 = {DE1, hsync1, vsync1, ctrl_b1, x1, y1, fs1, red1, green1, blue1};

  function automatic exp_t model(int h, int v, int ha, int hf, int hsw,
                                 int va, int vf, int vsw, bit hp, bit vp);
    exp_t        e;
    bit          act;
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    act   = (h < ha) && (v < va);
    e.de  = act;
    e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    e.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    e.cb  = {e.vs, e.hs};
    e.x   = act ? 12'(h) : 12'd0;
    e.y   = act ? 11'(v) : 11'd0;
    e.fs  = (h == 0) && (v == 0);
    e.rgb = act ? tbl[(h * 8) / ha] : 24'h0;
    return e;
  endfunction

  function automatic exp_t rst_val(bit hp, bit vp);
    exp_t e;
    e    = '0;
    e.hs = !hp;
    e.vs = !vp;
    e.cb = {!vp, !hp};
    return e;
  endfunction

  // Scoreboard producer: expected output for the counter state seen at this edge
  always @(posedge pixclk) begin
    if (rst0) begin
      q0.push_back(rst_val(1'b0, 1'b0));
      mh0 <= 0;
      mv0 <= 0;
    end else begin
      q0.push_back(model(mh0, mv0, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
      mh0 <= (mh0 == 799) ? 0 : mh0 + 1;
      if (mh0 == 799) mv0 <= (mv0 == 524) ? 0 : mv0 + 1;
    end
    if (rst1) begin
      q1.push_back(rst_val(1'b1, 1'b1));
      mh1 <= 0;
      mv1 <= 0;
    end else begin
      q1.push_back(model(mh1, mv1, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b1, 1'b1));
      mh1 <= (mh1 == S_HT - 1) ? 0 : mh1 + 1;
      if (mh1 == S_HT - 1) mv1 <= (mv1 == S_VT - 1) ? 0 : mv1 + 1;
    end
  end

  task automatic step();
    @(negedge pixclk);
    if (q0.size() == 0 || q1.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow q0=%0d q1=%0d", q0.size(), q1.size());
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "scoreboard underflow");
    end
    e0 = q0.pop_front();
    e1 = q1.pop_front();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (act0 !== e0) begin errors++; $display("FAIL reset_dut0 got %h want %h", act0, e0); end
      checks++;
      if (act1 !== e1) begin errors++; $display("FAIL reset_dut1 got %h want %h", act1, e1); end
    end
    checks++;
    if ({DE0, hsync0, vsync0, red0, green0, blue0} !== {3'b011, 24'h0}) begin
      errors++;
      $display("FAIL reset_values_dut0 got de=%b hs=%b vs=%b rgb=%h want de=0 hs=1 vs=1 rgb=0",
               DE0, hsync0, vsync0, {red0, green0, blue0});
    end
    checks++;
    if ({hsync1, vsync1} !== 2'b00) begin
      errors++; $display("FAIL reset_pol_dut1 got hs=%b vs=%b want 0 0", hsync1, vsync1);
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
  endtask

  task automatic test_line0();
    int de_cnt = 0, hs_first = -1, hs_last = -1;
    logic [23:0] want;
    bit          chk;
    for (int i = 0; i < 800; i++) begin
      step();
      checks++;
      if (act0 !== e0) begin errors++; $display("FAIL line0_dut0 cyc %0d got %h want %h", i, act0, e0); end
      checks++;
      if (act1 !== e1) begin errors++; $display("FAIL line0_dut1 cyc %0d got %h want %h", i, act1, e1); end
      if (i == 0) begin
        checks++;
        if ({DE0, fs0, x0, red0, green0, blue0} !== {2'b11, 12'd0, 24'hFFFFFF}) begin
          errors++;
          $display("FAIL first_edge got de=%b fs=%b x=%0d rgb=%h want 1 1 0 ffffff",
                   DE0, fs0, x0, {red0, green0, blue0});
        end
      end
      if (DE0 === 1'b1) de_cnt++;
      if (hsync0 === 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      checks++;
      if (ctrl_b0[0] !== hsync0) begin
        errors++; $display("FAIL ctrl_b_track cyc %0d got %b want %b", i, ctrl_b0[0], hsync0);
      end
      chk = 1'b1;
      case (i)
        0, 79:    want = 24'hFFFFFF;
        80:       want = 24'hFFFF00;
        400:      want = 24'hFF0000;
        639, 700: want = 24'h000000;
        default:  chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if ({red0, green0, blue0} !== want) begin
          errors++; $display("FAIL colour_bar x=%0d got %h want %h", i, {red0, green0, blue0}, want);
        end
      end
    end
    checks++;
    if (de_cnt !== 640) begin errors++; $display("FAIL line0_de_count got %0d want 640", de_cnt); end
    checks++;
    if (hs_first !== 656 || hs_last !== 751) begin
      errors++; $display("FAIL line0_hsync_window got %0d..%0d want 656..751", hs_first, hs_last);
    end
  endtask

  task automatic test_frame_small();
    bit found = 1'b0;
    int vs_cnt = 0, vs_first = -1, hs_first = -1, hs_last = -1;
    for (int n = 0; n < 2000 && !found; n++) begin
      step();
      checks++;
      if (act1 !== e1) begin errors++; $display("FAIL frame_seek got %h want %h", act1, e1); end
      if (fs1 === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL frame_start_timeout got none want pulse within 2000");
    end else begin
      for (int c = 1; c < S_HT * S_VT; c++) begin
        step();
        checks++;
        if (act1 !== e1) begin errors++; $display("FAIL frame_dut1 c=%0d got %h want %h", c, act1, e1); end
        if (vsync1 === 1'b1) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = c;
        end
        if (c < S_HT && hsync1 === 1'b1) begin
          if (hs_first < 0) hs_first = c;
          hs_last = c;
        end
        if (c / S_HT >= S_VA) begin
          checks++;
          if (DE1 !== 1'b0) begin errors++; $display("FAIL de_in_vblank c=%0d got %b want 0", c, DE1); end
        end
        checks++;
        if (fs1 !== 1'b0) begin errors++; $display("FAIL spurious_frame_start c=%0d got %b want 0", c, fs1); end
      end
      step();
      checks++;
      if (fs1 !== 1'b1) begin errors++; $display("FAIL frame_period got fs=%b want 1 at %0d", fs1, S_HT * S_VT); end
      checks++;
      if (vs_cnt !== S_VS * S_HT || vs_first !== (S_VA + S_VF) * S_HT) begin
        errors++;
        $display("FAIL vsync_window got cnt=%0d first=%0d want cnt=%0d first=%0d",
                 vs_cnt, vs_first, S_VS * S_HT, (S_VA + S_VF) * S_HT);
      end
      checks++;
      if (hs_first !== S_HA + S_HF || hs_last !== S_HA + S_HF + S_HS - 1) begin
        errors++;
        $display("FAIL hsync_pos_window got %0d..%0d want %0d..%0d",
                 hs_first, hs_last, S_HA + S_HF, S_HA + S_HF + S_HS - 1);
      end
    end
  endtask

  task automatic test_mid_reset_default();
    bit hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      if (mh0 == 300) hit = 1'b1;
      else step();
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL mid_reset_seek_dut0 got timeout want h=300");
    end else begin
      rst0 = 1'b1;
      step();
      checks++;
      if (act0 !== rst_val(1'b0, 1'b0)) begin
        errors++; $display("FAIL mid_reset_value_dut0 got %h want %h", act0, rst_val(1'b0, 1'b0));
      end
      rst0 = 1'b0;
      step();
      checks++;
      if ({DE0, fs0, x0, y0, red0, green0, blue0} !== {2'b11, 23'd0, 24'hFFFFFF}) begin
        errors++;
        $display("FAIL mid_reset_restart_dut0 got de=%b fs=%b x=%0d y=%0d rgb=%h want 1 1 0 0 ffffff",
                 DE0, fs0, x0, y0, {red0, green0, blue0});
      end
      for (int i = 0; i < 100; i++) begin
        step();
        checks++;
        if (act0 !== e0) begin errors++; $display("FAIL after_reset_dut0 cyc %0d got %h want %h", i, act0, e0); end
      end
    end
  endtask

  task automatic test_mid_reset_small();
    bit hit = 1'b0;
    int period = 0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      if (mh1 == 20 && mv1 == 7) hit = 1'b1;
      else step();
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL mid_reset_seek_dut1 got timeout want (20,7)");
    end else begin
      rst1 = 1'b1;
      step();
      checks++;
      if (act1 !== rst_val(1'b1, 1'b1)) begin
        errors++; $display("FAIL mid_reset_value_dut1 got %h want %h", act1, rst_val(1'b1, 1'b1));
      end
      rst1 = 1'b0;
      step();
      checks++;
      if ({fs1, DE1, x1} !== {2'b11, 12'd0}) begin
        errors++; $display("FAIL mid_reset_restart_dut1 got fs=%b de=%b x=%0d want 1 1 0", fs1, DE1, x1);
      end
      for (int n = 1; n < 2000 && period == 0; n++) begin
        step();
        checks++;
        if (act1 !== e1) begin errors++; $display("FAIL post_reset_frame n=%0d got %h want %h", n, act1, e1); end
        if (fs1 === 1'b1) period = n;
      end
      checks++;
      if (period !== S_HT * S_VT) begin
        errors++; $display("FAIL post_reset_period got %0d want %0d", period, S_HT * S_VT);
      end
    end
  endtask

  task automatic test_reset_on_wrap();
    bit hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      if (mh1 == S_HT - 1 && mv1 == S_VT - 1) hit = 1'b1;
      else step();
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL wrap_seek got timeout want frame end");
    end else begin
      rst1 = 1'b1;
      step();
      checks++;
      if ({DE1, fs1, hsync1, vsync1} !== 4'b0000) begin
        errors++; $display("FAIL reset_on_wrap got de=%b fs=%b hs=%b vs=%b want 0 0 0 0", DE1, fs1, hsync1, vsync1);
      end
      rst1 = 1'b0;
      step();
      checks++;
      if ({fs1, DE1, x1, y1} !== {2'b11, 23'd0}) begin
        errors++; $display("FAIL wrap_restart got fs=%b de=%b x=%0d y=%0d want 1 1 0 0", fs1, DE1, x1, y1);
      end
      for (int i = 0; i < 200; i++) begin
        step();
        checks++;
        if (act1 !== e1) begin errors++; $display("FAIL after_wrap_dut1 cyc %0d got %h want %h", i, act1, e1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line0();
    test_frame_small();
    test_mid_reset_default();
    test_mid_reset_small();
    test_reset_on_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
